booth_rr_scheduler: RTL and testbench

//  Shares one booth_fsm multiplier between NUM_REQ requesters.

---
 rtl/booth_rr_scheduler.sv | 119 +++++++++++
 tb/tb_booth_rr_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_rr_scheduler.sv
// booth_rr_scheduler: time-shares one booth_fsm multiplier between NUM_REQ
// valid/ready requesters with round-robin arbitration and a private result return.
module booth_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_m,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [2*DATA_WIDTH-1:0]       rsp_product,
    output logic                          mul_load,
    output logic [DATA_WIDTH-1:0]         mul_m,
    output logic [DATA_WIDTH-1:0]         mul_r,
    input  logic [2*DATA_WIDTH-1:0]       mul_product,
    input  logic                          mul_done,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id,
    output logic [15:0]                   last_latency
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESPOND} state_t;

    state_t                  state_reg, state_next;
    logic [ID_W-1:0]         ptr_reg;
    logic [ID_W-1:0]         grant_id_reg;
    logic [ID_W-1:0]         winner;
    logic                    found;
    logic                    accept;
    logic                    rsp_fire;
    logic [DATA_WIDTH-1:0]   m_reg, r_reg;
    logic [DATA_WIDTH-1:0]   m_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   r_arr [NUM_REQ];
    logic [2*DATA_WIDTH-1:0] product_reg;
    logic [15:0]             cnt_reg;
    logic [15:0]             last_latency_reg;

    // Search starts just after the last owner, so the previous winner has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[ID_W'((int'(ptr_reg) + k) % NUM_REQ)]) begin
                found  = 1'b1;
                winner = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
            end
        end
    end

    assign accept   = (state_reg == IDLE) && found && mul_done && !reset;
    assign rsp_fire = (state_reg == RESPOND) && rsp_ready[grant_id_reg];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign m_arr[gi]     = req_m[gi*DATA_WIDTH +: DATA_WIDTH];
            assign r_arr[gi]     = req_r[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = accept && (winner == ID_W'(gi));
            assign rsp_valid[gi] = (state_reg == RESPOND) && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (accept)    state_next = ISSUE;
            ISSUE:                     state_next = WAIT_START;
            WAIT_START: if (!mul_done) state_next = WAIT_DONE;
            WAIT_DONE:  if (mul_done)  state_next = RESPOND;
            RESPOND:    if (rsp_fire)  state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            ptr_reg          <= ID_W'(NUM_REQ - 1);
            grant_id_reg     <= '0;
            m_reg            <= '0;
            r_reg            <= '0;
            product_reg      <= '0;
            cnt_reg          <= '0;
            last_latency_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                m_reg        <= m_arr[winner];
                r_reg        <= r_arr[winner];
                grant_id_reg <= winner;
                ptr_reg      <= winner;
            end
            // The ISSUE cycle itself counts as one, so last_latency = ISSUE-to-done distance.
            if (state_reg == ISSUE) begin
                cnt_reg <= 16'd1;
            end else if ((state_reg == WAIT_START || state_reg == WAIT_DONE) && cnt_reg != 16'hFFFF) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
            if (state_reg == WAIT_DONE && mul_done) begin
                product_reg      <= mul_product;
                last_latency_reg <= cnt_reg;
            end
        end
    end

    assign mul_load     = (state_reg == ISSUE);
    assign mul_m        = m_reg;
    assign mul_r        = r_reg;
    assign busy         = (state_reg != IDLE);
    assign grant_id     = grant_id_reg;
    assign rsp_product  = product_reg;
    assign last_latency = last_latency_reg;

endmodule

// File: tb/tb_booth_rr_scheduler.sv
// Testbench for booth_rr_scheduler: behavioural multiplier stub, table vectors,
// hand-written corner sequences and a randomized run against a round-robin model.
module tb_booth_rr_scheduler;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_m = '0;
    logic [NR*DW-1:0]  req_r = '0;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready = '0;
    logic [2*DW-1:0]   rsp_product;
    logic              mul_load;
    logic [DW-1:0]     mul_m, mul_r;
    logic [2*DW-1:0]   mul_product;
    logic              mul_done;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [15:0]       last_latency;

    int n_vec = 0;
    int n_err = 0;
    int mul_lat = 2;
    logic hold_done = 1'b0;
    int busy_cnt = 0;
    logic signed [2*DW-1:0] target = '0;
    int load_pulses = 0;
    int last_wait = 0;

    typedef struct {
        int          port;
        logic [31:0] m;
        logic [31:0] r;
        int          lat;
        logic [63:0] prod;
    } vec_t;
    vec_t tbl [6];

    logic [31:0]            mv [NR];
    logic [31:0]            rv [NR];
    logic signed [63:0]     exp_prod;
    int                     model_ptr;

    always #5 clk = ~clk;

    booth_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_r(req_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
        .mul_load(mul_load), .mul_m(mul_m), .mul_r(mul_r),
        .mul_product(mul_product), .mul_done(mul_done),
        .busy(busy), .grant_id(grant_id), .last_latency(last_latency)
    );

    // Multiplier stub: busy for mul_lat cycles after a load, garbage product while busy.
    always @(posedge clk) begin
        if (mul_load) begin
            busy_cnt <= mul_lat;
            target   <= $signed(mul_m) * $signed(mul_r);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign mul_done    = (busy_cnt == 0) && !hold_done;
    assign mul_product = (busy_cnt == 0) ? target : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(negedge clk) if (mul_load) load_pulses++;

    function automatic logic [NR-1:0] oh(input int p);
        return NR'(1) << p;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            if (((v >> ((ptr + k) % NR)) & NR'(1)) != '0) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] m, input logic [31:0] r);
        req_m[p*DW +: DW] = m;
        req_r[p*DW +: DW] = r;
        req_valid = req_valid | oh(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called just after a negedge with requests driven; runs one op to completion.
    task automatic serve(input int port, input logic [63:0] want, input int stall,
                         input bit drop, input logic [NR-1:0] side);
        int cyc;
        int lp0;
        bit ok;
        lp0 = load_pulses;
        ok = 1'b0;
        last_wait = 0;
        #1;
        for (int i = 0; i < 300; i++) begin
            if (req_ready != '0) begin ok = 1'b1; break; end
            @(negedge clk); #1;
            last_wait++;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: port %0d saw no req_ready, expected a grant", port);
            return;
        end
        check("req_ready_grant", req_ready, oh(port));
        @(negedge clk);
        if (drop) req_valid = req_valid & ~oh(port);
        cyc = 1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid != '0) begin ok = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout: port %0d saw no rsp_valid, expected a response", port);
            return;
        end
        check("rsp_valid_owner", rsp_valid, oh(port));
        check("rsp_product", rsp_product, want);
        check("grant_id", grant_id, 64'(port));
        check("accept_to_rsp", 64'(cyc), 64'(3 + mul_lat));
        check("last_latency", last_latency, 64'(mul_lat + 1));
        check("mul_load_pulses", 64'(load_pulses - lp0), 64'd1);
        $display("op port=%0d product=%h latency=%0d", port, rsp_product, last_latency);
        rsp_ready = ~oh(port);
        req_valid = req_valid | side;
        for (int s = 0; s < stall; s++) begin
            #1;
            check("stall_rsp_valid", rsp_valid, oh(port));
            check("stall_product", rsp_product, want);
            check("stall_req_ready", req_ready, '0);
            check("stall_busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = oh(port);
        req_valid = req_valid & ~side;
        @(negedge clk);
        rsp_ready = '0;
        check("idle_after_rsp", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2, 32'd3,          32'd5,          2, 64'd15};
        tbl[1] = '{0, 32'hFFFF_FFF9,  32'd6,          3, 64'hFFFF_FFFF_FFFF_FFD6};
        tbl[2] = '{1, 32'd2,          32'hFFFF_FFFD,  1, 64'hFFFF_FFFF_FFFF_FFFA};
        tbl[3] = '{3, 32'h8000_0000,  32'h8000_0000,  5, 64'h4000_0000_0000_0000};
        tbl[4] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4, 64'd1};
        tbl[5] = '{3, 32'h7FFF_FFFF,  32'd2,          6, 64'h0000_0000_FFFF_FFFE};

        // Reset state
        do_reset();
        #1;
        check("reset_req_ready", req_ready, '0);
        check("reset_rsp_valid", rsp_valid, '0);
        check("reset_mul_load", mul_load, 0);
        check("reset_busy", busy, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_last_latency", last_latency, 0);

        // Table vectors, one requester at a time
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mul_lat = tbl[i].lat;
            set_req(tbl[i].port, tbl[i].m, tbl[i].r);
            serve(tbl[i].port, tbl[i].prod, 0, 1'b1, '0);
        end

        // Response stalled 10 cycles while another port is requesting
        mul_lat = 2;
        set_req(1, 32'd100, 32'hFFFF_FFFF);
        serve(1, 64'hFFFF_FFFF_FFFF_FF9C, 10, 1'b1, oh(0));

        // Multiplier not idle: no accept until mul_done rises
        @(negedge clk);
        hold_done = 1'b1;
        set_req(3, 32'd11, 32'd13);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("held_req_ready", req_ready, '0);
            check("held_busy", busy, 0);
            @(negedge clk);
        end
        hold_done = 1'b0;
        serve(3, 64'd143, 0, 1'b1, '0);
        check("accept_on_done_rise", 64'(last_wait), 64'd0);

        // Reset while waiting for the multiplier drops the op
        @(negedge clk);
        mul_lat = 20;
        set_req(2, 32'd9, 32'd9);
        #1;
        check("pre_reset_grant", req_ready, oh(2));
        repeat (5) @(negedge clk);
        req_valid = '0;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_mul_load", mul_load, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_last_latency", last_latency, 0);
        @(negedge clk);
        mul_lat = 3;
        set_req(1, 32'd2, 32'hFFFF_FFFD);
        serve(1, 64'hFFFF_FFFF_FFFF_FFFA, 0, 1'b1, '0);

        // All four requesting continuously: grants 0,1,2,3,0
        do_reset();
        mul_lat = 2;
        for (int p = 0; p < NR; p++) set_req(p, 32'(p + 1), 32'(10 + p));
        serve(0, 64'd10, 0, 1'b0, '0);
        serve(1, 64'd22, 0, 1'b0, '0);
        serve(2, 64'd36, 0, 1'b0, '0);
        serve(3, 64'd52, 0, 1'b0, '0);
        serve(0, 64'd10, 0, 1'b0, '0);
        req_valid = '0;

        // Randomized masks, operands, multiplier latency and response stalls
        do_reset();
        model_ptr = NR - 1;
        for (int t = 0; t < 40; t++) begin
            logic [NR-1:0] mask;
            int w;
            @(negedge clk);
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int p = 0; p < NR; p++) begin
                mv[p] = $urandom();
                rv[p] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 9)) : $urandom();
                if (((mask >> p) & NR'(1)) != '0) set_req(p, mv[p], rv[p]);
            end
            w = rr_pick(mask, model_ptr);
            exp_prod = $signed(mv[w]) * $signed(rv[w]);
            mul_lat = $urandom_range(1, 6);
            serve(w, exp_prod, $urandom_range(0, 3), 1'b1, '0);
            req_valid = '0;
            model_ptr = w;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
